// File: rtl/cam_match_iter_pkg.sv
// Shared CAM match-iterator definitions.
// Holds the entry geometry, the count width and the iterator state enum.
package cam_match_iter_pkg;

    localparam int ENTRIES = 128;
    localparam int IDX_W   = 7;
    localparam int CNT_W   = 8;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

endpackage

// File: rtl/cam_match_iter_if.sv
// Handshake bundle between the CAM lookup stage, the iterator and its consumer.
// Inputs:  match_valid/match_vec/flush from the lookup side, res_ready from the consumer.
// Outputs: match_ready to the lookup side; res_valid/hit/idx/last/cnt to the consumer.
interface cam_match_iter_if;
    import cam_match_iter_pkg::*;

    logic               match_valid;
    logic               match_ready;
    logic [ENTRIES-1:0] match_vec;
    logic               flush;
    logic               res_valid;
    logic               res_ready;
    logic               res_hit;
    logic [IDX_W-1:0]   res_idx;
    logic               res_last;
    logic [CNT_W-1:0]   res_cnt;

    modport master (
        output match_valid, match_vec, flush, res_ready,
        input  match_ready, res_valid, res_hit, res_idx, res_last, res_cnt
    );

    modport slave (
        input  match_valid, match_vec, flush, res_ready,
        output match_ready, res_valid, res_hit, res_idx, res_last, res_cnt
    );

endinterface

// File: rtl/cam_match_iter_prienc.sv
// Lowest-set-bit priority encoder over the 128-entry pending vector.
// Inputs: pend (128 bits). Outputs: res_idx (7 bits), 0 when pend is empty.
module prienc_128_7
    import cam_match_iter_pkg::*;
(
    input  logic [ENTRIES-1:0] pend,
    output logic [IDX_W-1:0]   res_idx
);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        res_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                res_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam_match_iter.sv
// Iterates a CAM match vector, emitting one beat per matching entry, lowest first.
// Ports: clk, rst_n (async active-low), bus (slave side of cam_match_iter_if).
module cam_match_iter #(
    parameter int ENTRIES = cam_match_iter_pkg::ENTRIES,
    parameter int IDX_W   = cam_match_iter_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    cam_match_iter_if.slave   bus
);
    import cam_match_iter_pkg::state_e;
    import cam_match_iter_pkg::IDLE;
    import cam_match_iter_pkg::SCAN;

    state_e             state_q, state_d;
    logic [ENTRIES-1:0] pend_q, pend_d;
    logic [ENTRIES-1:0] pend_rest;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   low_idx;
    logic               hit;
    logic               last;

    prienc_128_7 u_prienc (
        .pend    (pend_q),
        .res_idx (low_idx)
    );

    // pend with its lowest set bit removed; empty means at most one bit left.
    assign pend_rest = pend_q & (pend_q - ENTRIES'(1));
    assign hit       = |pend_q;
    assign last      = ~|pend_rest;

    assign bus.match_ready = (state_q == IDLE) && !bus.flush;
    assign bus.res_valid   = (state_q == SCAN);
    assign bus.res_hit     = hit;
    assign bus.res_idx     = low_idx;
    assign bus.res_last    = last;
    assign bus.res_cnt     = cnt_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = IDLE;
            pend_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.match_valid) begin
                        pend_d  = bus.match_vec;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (bus.res_ready) begin
                        if (hit) begin
                            pend_d = pend_rest;
                            cnt_d  = cnt_q + 8'd1;
                            if (last) begin
                                state_d = IDLE;
                            end
                        end else begin
                            // Empty vector: its single miss beat is done.
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cam_match_iter.sv
// Self-checking bench for cam_match_iter: queue model plus directed literal checks.
module tb_cam_match_iter;

    logic clk;
    logic rst_n;

    cam_match_iter_if bus ();

    cam_match_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Model: queue of matching indices still to be emitted.
    bit m_scan;
    int m_q[$];
    int m_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_scan = 1'b0;
            m_q.delete();
            m_cnt = 0;
        end
        chk("m_valid", 32'(bus.res_valid), 32'(m_scan));
        chk("m_ready", 32'(bus.match_ready), 32'(!m_scan && !bus.flush));
        chk("m_cnt", 32'(bus.res_cnt), 32'(m_cnt));
        if (m_scan) begin
            chk("m_hit", 32'(bus.res_hit), 32'(m_q.size() > 0));
            chk("m_idx", 32'(bus.res_idx), 32'(m_q.size() > 0 ? m_q[0] : 0));
            chk("m_last", 32'(bus.res_last), 32'(m_q.size() <= 1));
        end
        if (rst_n) begin
            if (bus.flush) begin
                m_scan = 1'b0;
                m_q.delete();
                m_cnt = 0;
            end else if (!m_scan && bus.match_valid) begin
                m_q.delete();
                for (int i = 0; i < 128; i++) begin
                    if (bus.match_vec[i]) m_q.push_back(i);
                end
                m_cnt = 0;
                m_scan = 1'b1;
            end else if (m_scan && bus.res_ready) begin
                if (m_q.size() > 0) begin
                    void'(m_q.pop_front());
                    m_cnt++;
                    if (m_q.size() == 0) m_scan = 1'b0;
                end else begin
                    m_scan = 1'b0;
                end
            end
        end
    end

    // Offers a vector once the block is ready; returns 1 ns after acceptance.
    task automatic send(input logic [127:0] v);
        int k;
        k = 0;
        while (!bus.match_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k == 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got busy, expected ready");
        end
        bus.match_valid = 1'b1;
        bus.match_vec   = v;
        @(posedge clk);
        #1;
        bus.match_valid = 1'b0;
        bus.match_vec   = '0;
    endtask

    task automatic beat(input string nm, input int idx, input bit hit,
                        input bit last, input int cnt);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.res_valid), 32'd1);
        chk({nm, "_hit"}, 32'(bus.res_hit), 32'(hit));
        chk({nm, "_idx"}, 32'(bus.res_idx), 32'(idx));
        chk({nm, "_last"}, 32'(bus.res_last), 32'(last));
        chk({nm, "_cnt"}, 32'(bus.res_cnt), 32'(cnt));
    endtask

    task automatic idle_chk(input string nm, input int cnt);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.res_valid), 32'd0);
        chk({nm, "_ready"}, 32'(bus.match_ready), 32'd1);
        chk({nm, "_cnt"}, 32'(bus.res_cnt), 32'(cnt));
    endtask

    logic [127:0] v;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.match_valid = 1'b0;
        bus.match_vec = '0;
        bus.flush = 1'b0;
        bus.res_ready = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_hit", 32'(bus.res_hit), 32'd0);
        chk("rst_idx", 32'(bus.res_idx), 32'd0);
        chk("rst_last", 32'(bus.res_last), 32'd1);
        chk("rst_ready", 32'(bus.match_ready), 32'd1);
        chk("rst_cnt", 32'(bus.res_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Three sparse matches, streaming
        v = '0;
        v[3] = 1'b1;
        v[64] = 1'b1;
        v[127] = 1'b1;
        send(v);
        beat("b3", 3, 1'b1, 1'b0, 0);
        beat("b64", 64, 1'b1, 1'b0, 1);
        beat("b127", 127, 1'b1, 1'b1, 2);
        idle_chk("after3", 3);

        // Empty vector
        send('0);
        beat("empty", 0, 1'b0, 1'b1, 0);
        idle_chk("after_empty", 0);

        // Back-pressure holds the beat
        bus.res_ready = 1'b0;
        v = 128'h3;
        send(v);
        for (int i = 0; i < 5; i++) begin
            beat("hold", 0, 1'b1, 1'b0, 0);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        beat("rel0", 0, 1'b1, 1'b0, 0);
        beat("rel1", 1, 1'b1, 1'b1, 1);
        idle_chk("after_hold", 2);

        // All entries matched
        send('1);
        for (int i = 0; i < 128; i++) begin
            beat("all", i, 1'b1, i == 127, i);
        end
        idle_chk("after_all", 128);

        // Flush after the first beat
        v = '0;
        v[10] = 1'b1;
        v[20] = 1'b1;
        send(v);
        beat("f10", 10, 1'b1, 1'b0, 0);
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 32'(bus.match_ready), 32'd0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        idle_chk("after_flush", 0);

        // Flush rejects a vector offered in IDLE
        bus.flush = 1'b1;
        bus.match_valid = 1'b1;
        bus.match_vec = '1;
        @(negedge clk);
        chk("flush_idle_ready", 32'(bus.match_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.match_valid = 1'b0;
        bus.match_vec = '0;
        idle_chk("flush_reject", 0);

        // Reset in the middle of a scan
        bus.res_ready = 1'b0;
        v = '0;
        v[5] = 1'b1;
        v[6] = 1'b1;
        send(v);
        beat("pre_rst", 5, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.match_ready), 32'd1);
        chk("mid_rst_last", 32'(bus.res_last), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.res_ready = 1'b1;
        idle_chk("post_rst", 0);
        v = '0;
        v[9] = 1'b1;
        send(v);
        beat("b9", 9, 1'b1, 1'b1, 0);
        idle_chk("after9", 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/cam_match_iter.md
CAM_MATCH_ITER -- requirements
Module: cam_match_iter

Interface
REQ-001 Parameter ENTRIES, default 128, number of CAM entries; only 128 is supported.
REQ-002 Parameter IDX_W, default 7, entry index width; equals log2(ENTRIES).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port match_valid  input  1  match vector from the CAM lookup stage is valid.
REQ-006 Port match_ready  output  1  block accepts a match vector.
REQ-007 Port match_vec  input  ENTRIES  one bit per CAM entry; bit i set means entry i matched.
REQ-008 Port flush  input  1  abort the current vector and discard it.
REQ-009 Port res_valid  output  1  result beat valid.
REQ-010 Port res_ready  input  1  downstream accepts the result beat.
REQ-011 Port res_hit  output  1  1 = res_idx is a matching entry; 0 = vector had no matches.
REQ-012 Port res_idx  output  IDX_W  matching entry index, lowest remaining index first.
REQ-013 Port res_last  output  1  final beat for the current vector.
REQ-014 Port res_cnt  output  8  number of hit beats already accepted for the current vector (0..128).

Function
REQ-015 FSM states SHALL be IDLE and SCAN.
REQ-016 IDLE: match_ready=1, res_valid=0; match_valid&&match_ready captures match_vec into pending register pend, clears res_cnt, and moves to SCAN.
REQ-017 SCAN: match_ready=0, res_valid=1; the input is not accepted while in SCAN.
REQ-018 res_idx SHALL equal the index of the lowest set bit of pend; res_hit=|pend.
REQ-019 res_last SHALL be 1 when pend has at most one set bit.
REQ-020 Outputs SHALL be driven from registered state only; first res_valid appears the cycle after vector acceptance.
REQ-021 On res_valid&&res_ready with res_hit=1: clear bit res_idx in pend and increment res_cnt; if res_last, go to IDLE.
REQ-022 An empty vector SHALL produce exactly one beat: res_hit=0, res_idx=0, res_last=1, res_cnt=0; acceptance returns to IDLE.
REQ-023 Throughput: one beat per cycle while res_ready=1; N matches give N beats in N cycles, plus one IDLE cycle before the next vector is accepted.
REQ-024 res_valid=1 with res_ready=0 SHALL hold res_idx, res_hit, res_last and res_cnt stable until accepted.
REQ-025 flush SHALL take priority over every handshake: next state IDLE, pend=0, res_cnt=0, and no beat counted in that cycle.
REQ-026 flush asserted in IDLE together with match_valid SHALL reject the vector; match_ready is forced to 0 while flush=1.
REQ-027 res_cnt SHALL reach 128 without wrapping when all 128 bits are set.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, pend=0, res_cnt=0.
REQ-029 During reset, outputs SHALL be res_valid=0, res_hit=0, res_idx=0, res_last=1 (pend empty), and match_ready=1.
REQ-030 Reset asserted mid-SCAN SHALL discard the vector; no further beats are produced for it.
REQ-031 Reset SHALL be released synchronously to clk by the system; this block has no internal synchronizer.

Structure
REQ-032 ENTRIES, IDX_W, and the state enum (IDLE, SCAN) SHALL live in the shared cam package.
REQ-033 Lowest-set-bit selection SHALL use the existing prienc_128_7 block as the single sub-module, with input pend and output res_idx.
REQ-034 Clear-lowest-bit and single-bit detection (pend & (pend-1)) SHALL be local logic.

Verification
REQ-035 Vector bits {3,64,127} set, res_ready=1 -> beats idx 3,64,127 on consecutive cycles; last=1 only on 127; res_cnt reads 0,1,2.
REQ-036 Vector all-zero -> single beat hit=0, last=1, idx=0; match_ready back to 1 the next cycle.
REQ-037 Vector bits {0,1} with res_ready low for 5 cycles -> idx=0 held stable for 5 cycles, then beats 0 and 1.
REQ-038 Vector all-ones -> 128 beats idx 0..127 in order; last only on idx 127; final res_cnt=127, then 128 internally before clearing on the next vector.
REQ-039 Vector {10,20}; flush on the cycle after beat 10 -> no beat 20; IDLE and match_ready=1 the next cycle.
REQ-040 rst_n low during SCAN of {5,6} -> res_valid drops immediately; after release, a new vector {9} yields a single beat idx=9, last=1.
